// File: rtl/cc_game_pkg.sv
// ---------------------------------------------------------------------------
// cc_game_pkg
// Shared definitions for the two-player LED-row ball game:
//   - game_state_e : SERVE / MOVE / POINT / GAMEOVER (2-bit encoding)
//   - DIR_L / DIR_R: ball travel toward bit DATAWIDTH-1 (player 1 end) or
//                    toward bit 0 (player 2 end)
//   - JUG1 / JUG2  : player identifiers, also used as indices into the
//                    per-player signal vectors in the top level
//   - window_open  : a comparator window is open when either active-low
//                    flag is asserted
// ---------------------------------------------------------------------------
package cc_game_pkg;

    typedef enum logic [1:0] {
        ST_SERVE    = 2'd0,
        ST_MOVE     = 2'd1,
        ST_POINT    = 2'd2,
        ST_GAMEOVER = 2'd3
    } game_state_e;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    localparam logic JUG1 = 1'b0;
    localparam logic JUG2 = 1'b1;

    function automatic logic window_open(input logic [1:0] flags_n);
        return (flags_n != 2'b11);
    endfunction

endpackage

// File: rtl/cc_tickprescaler.sv
// ---------------------------------------------------------------------------
// cc_tickprescaler
// Prescaler for the ball step rate. Counts 0..period-1 and pulses tick_o for
// one cycle on the last count, after which the counter wraps to 0.
//
// Optional feature (macro CC_BALLCONTROLLER_SPEEDUP_EN):
//   defined   - the period is a register loaded with TICK_CYCLES at reset and
//               on reload_i; each speedup_i pulse shortens it by
//               max(TICK_CYCLES/8,1), never going below max(TICK_CYCLES/4,1).
//   undefined - fixed period TICK_CYCLES; reload_i / speedup_i are ignored.
//
// Ports:
//   clk_i      system clock
//   srst_i     synchronous active-high reset
//   clear_i    restart the count from 0 (asserted on every game-state entry)
//   reload_i   restore the base period (SERVE entry)
//   speedup_i  shorten the period (successful return)
//   tick_o     one-cycle step strobe
// ---------------------------------------------------------------------------
module cc_tickprescaler #(
    parameter int TICK_CYCLES = 25000000,
    parameter int TICK_WIDTH  = 25
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic clear_i,
    input  logic reload_i,
    input  logic speedup_i,
    output logic tick_o
);

    logic [TICK_WIDTH-1:0] cnt_q;
    logic [TICK_WIDTH-1:0] cnt_d;
    logic [TICK_WIDTH-1:0] last_count;

`ifdef CC_BALLCONTROLLER_SPEEDUP_EN
    localparam int STEP_I  = (TICK_CYCLES / 8 > 0) ? TICK_CYCLES / 8 : 1;
    localparam int FLOOR_I = (TICK_CYCLES / 4 > 0) ? TICK_CYCLES / 4 : 1;
    localparam logic [TICK_WIDTH-1:0] PERIOD_BASE = TICK_WIDTH'(TICK_CYCLES);
    localparam logic [TICK_WIDTH-1:0] PERIOD_STEP = TICK_WIDTH'(STEP_I);
    localparam logic [TICK_WIDTH-1:0] PERIOD_MIN  = TICK_WIDTH'(FLOOR_I);

    logic [TICK_WIDTH-1:0] period_q;
    logic [TICK_WIDTH-1:0] period_d;

    always_comb begin
        period_d = period_q;
        if (reload_i) begin
            period_d = PERIOD_BASE;
        end else if (speedup_i) begin
            // Compare before subtracting so the register never wraps.
            if (period_q >= PERIOD_MIN + PERIOD_STEP) begin
                period_d = period_q - PERIOD_STEP;
            end else begin
                period_d = PERIOD_MIN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            period_q <= PERIOD_BASE;
        end else begin
            period_q <= period_d;
        end
    end

    assign last_count = period_q - TICK_WIDTH'(1);
`else
    logic unused_speed_ctrl;
    assign unused_speed_ctrl = reload_i | speedup_i;
    assign last_count        = TICK_WIDTH'(TICK_CYCLES - 1);
`endif

    assign tick_o = (cnt_q == last_count);

    always_comb begin
        cnt_d = cnt_q + TICK_WIDTH'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cc_ballcontroller.sv
// ---------------------------------------------------------------------------
// cc_ballcontroller
// Game sequencer for the two-player LED-row ball game. Owns the one-hot ball
// register (LEDs + side comparators), steps it on the prescaled tick,
// reverses it on a valid hit, awards points and sequences
// SERVE -> MOVE -> POINT -> SERVE ... -> GAMEOVER.
//
// Ports:
//   CC_BALLCONTROLLER_CLOCK_50          system clock
//   CC_BALLCONTROLLER_RESET_InHigh      synchronous active-high reset
//   CC_BALLCONTROLLER_jug1Hit_InLow     player-1 button (low = pressed)
//   CC_BALLCONTROLLER_jug2Hit_InLow     player-2 button (low = pressed)
//   CC_BALLCONTROLLER_jug1Window_InLow  player-1 comparator flags, active low
//   CC_BALLCONTROLLER_jug2Window_InLow  player-2 comparator flags, active low
//   CC_BALLCONTROLLER_ball_OutBUS       one-hot ball position (zero in GAMEOVER)
//   CC_BALLCONTROLLER_score1_OutBUS     player-1 score
//   CC_BALLCONTROLLER_score2_OutBUS     player-2 score
//   CC_BALLCONTROLLER_gameOver_Out      high in GAMEOVER
//   CC_BALLCONTROLLER_winner_Out        0 = player 1, 1 = player 2
//
// Optional feature: CC_BALLCONTROLLER_SPEEDUP_EN (ball speeds up on each
// return; handled inside cc_tickprescaler).
// ---------------------------------------------------------------------------
module cc_ballcontroller
    import cc_game_pkg::*;
#(
    parameter int DATAWIDTH        = 8,
    parameter int TICK_CYCLES      = 25000000,
    parameter int TICK_WIDTH       = 25,
    parameter int SCORE_WIDTH      = 4,
    parameter int WIN_SCORE        = 5,
    parameter int POINT_HOLD_TICKS = 4
) (
    input  logic                   CC_BALLCONTROLLER_CLOCK_50,
    input  logic                   CC_BALLCONTROLLER_RESET_InHigh,
    input  logic                   CC_BALLCONTROLLER_jug1Hit_InLow,
    input  logic                   CC_BALLCONTROLLER_jug2Hit_InLow,
    input  logic [1:0]             CC_BALLCONTROLLER_jug1Window_InLow,
    input  logic [1:0]             CC_BALLCONTROLLER_jug2Window_InLow,
    output logic [DATAWIDTH-1:0]   CC_BALLCONTROLLER_ball_OutBUS,
    output logic [SCORE_WIDTH-1:0] CC_BALLCONTROLLER_score1_OutBUS,
    output logic [SCORE_WIDTH-1:0] CC_BALLCONTROLLER_score2_OutBUS,
    output logic                   CC_BALLCONTROLLER_gameOver_Out,
    output logic                   CC_BALLCONTROLLER_winner_Out
);

    localparam int HOLD_W = (POINT_HOLD_TICKS > 1) ? $clog2(POINT_HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(POINT_HOLD_TICKS - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN       = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [DATAWIDTH-1:0]   BALL_P1   = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [DATAWIDTH-1:0]   BALL_P2   = DATAWIDTH'(1);

    logic clk;
    logic srst;
    assign clk  = CC_BALLCONTROLLER_CLOCK_50;
    assign srst = CC_BALLCONTROLLER_RESET_InHigh;

    // Per-player vectors indexed by JUG1 / JUG2.
    logic [1:0] btn_n;
    logic [1:0] btn_q;
    logic [1:0] press;
    logic [1:0] win_open;

    assign btn_n = {CC_BALLCONTROLLER_jug2Hit_InLow, CC_BALLCONTROLLER_jug1Hit_InLow};

    always_ff @(posedge clk) begin
        if (srst) begin
            btn_q <= 2'b11;
        end else begin
            btn_q <= btn_n;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        // Falling edge of the active-low button: one pulse per press.
        assign press[gi] = btn_q[gi] & ~btn_n[gi];
    end

    assign win_open[JUG1] = window_open(CC_BALLCONTROLLER_jug1Window_InLow);
    assign win_open[JUG2] = window_open(CC_BALLCONTROLLER_jug2Window_InLow);

    // One step in the given direction. A step that would leave the row
    // (only possible after a hit at the far end) keeps the ball in place so
    // the bus stays one-hot.
    function automatic logic [DATAWIDTH-1:0] ball_step(input logic [DATAWIDTH-1:0] b,
                                                        input logic dir);
        if (dir == DIR_L) begin
            return b[DATAWIDTH-1] ? b : (b << 1);
        end
        return b[0] ? b : (b >> 1);
    endfunction

    game_state_e            state_q, state_d;
    logic [DATAWIDTH-1:0]   ball_q, ball_d;
    logic                   dir_q, dir_d;
    logic                   server_q, server_d;
    logic [SCORE_WIDTH-1:0] score1_q, score1_d;
    logic [SCORE_WIDTH-1:0] score2_q, score2_d;
    logic                   winner_q, winner_d;
    logic                   hit_q, hit_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;

    logic tick;
    logic returned;
    logic receiver;
    logic recv_press;
    logic at_recv_end;

    // The receiver is whoever owns the end the ball is heading for.
    assign receiver    = (dir_q == DIR_R) ? JUG2 : JUG1;
    assign recv_press  = press[receiver] & win_open[receiver];
    assign at_recv_end = (dir_q == DIR_R) ? ball_q[0] : ball_q[DATAWIDTH-1];

    always_comb begin
        state_d  = state_q;
        ball_d   = ball_q;
        dir_d    = dir_q;
        server_d = server_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        hit_d    = hit_q;
        hold_d   = hold_q;
        returned = 1'b0;

        unique case (state_q)
            ST_SERVE: begin
                if (press[server_q]) begin
                    state_d = ST_MOVE;
                    dir_d   = (server_q == JUG1) ? DIR_R : DIR_L;
                    hit_d   = 1'b0;
                end
            end

            ST_MOVE: begin
                if (tick) begin
                    hit_d = 1'b0;
                    // A press landing on the tick cycle still counts.
                    if (hit_q || recv_press) begin
                        dir_d    = ~dir_q;
                        ball_d   = ball_step(ball_q, ~dir_q);
                        returned = 1'b1;
                    end else if (!at_recv_end) begin
                        ball_d = ball_step(ball_q, dir_q);
                    end else begin
                        // Miss: opponent scores, the player who missed serves next.
                        if (receiver == JUG2) begin
                            score1_d = score1_q + SCORE_WIDTH'(1);
                        end else begin
                            score2_d = score2_q + SCORE_WIDTH'(1);
                        end
                        server_d = receiver;
                        hold_d   = '0;
                        state_d  = ST_POINT;
                    end
                end else if (recv_press) begin
                    hit_d = 1'b1;
                end
            end

            ST_POINT: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        if (score1_q == WIN || score2_q == WIN) begin
                            state_d  = ST_GAMEOVER;
                            ball_d   = '0;
                            winner_d = (score2_q == WIN) ? JUG2 : JUG1;
                        end else begin
                            state_d = ST_SERVE;
                            ball_d  = (server_q == JUG1) ? BALL_P1 : BALL_P2;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end

            ST_GAMEOVER: begin
                // Frozen until reset.
            end

            default: begin
                state_d = ST_SERVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= ST_SERVE;
            ball_q   <= BALL_P1;
            dir_q    <= DIR_R;
            server_q <= JUG1;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= JUG1;
            hit_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            ball_q   <= ball_d;
            dir_q    <= dir_d;
            server_q <= server_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
            hit_q    <= hit_d;
            hold_q   <= hold_d;
        end
    end

    logic presc_clear;
    logic presc_reload;
    assign presc_clear  = (state_d != state_q);
    assign presc_reload = presc_clear && (state_d == ST_SERVE);

    cc_tickprescaler #(
        .TICK_CYCLES (TICK_CYCLES),
        .TICK_WIDTH  (TICK_WIDTH)
    ) u_prescaler (
        .clk_i     (clk),
        .srst_i    (srst),
        .clear_i   (presc_clear),
        .reload_i  (presc_reload),
        .speedup_i (returned),
        .tick_o    (tick)
    );

    assign CC_BALLCONTROLLER_ball_OutBUS   = ball_q;
    assign CC_BALLCONTROLLER_score1_OutBUS = score1_q;
    assign CC_BALLCONTROLLER_score2_OutBUS = score2_q;
    assign CC_BALLCONTROLLER_gameOver_Out  = (state_q == ST_GAMEOVER);
    assign CC_BALLCONTROLLER_winner_Out    = winner_q;

endmodule
